// File: rtl/dec2bcd_if.sv
// dec2bcd_if: start/done request bus between the float split stage, dec2bcd and the display formatter.
//   master drives: start, sign_in, int_dec[31:0], frac_dec[31:0], ovf_in
//   slave drives:  busy, done, int_bcd[31:0], frac_bcd[4*FRAC_KEEP-1:0], int_ndig[3:0], sign_out, err
interface dec2bcd_if #(parameter int FRAC_KEEP = 9);
   logic                   start;
   logic                   sign_in;
   logic [31:0]            int_dec;
   logic [31:0]            frac_dec;
   logic                   ovf_in;
   logic                   busy;
   logic                   done;
   logic [31:0]            int_bcd;
   logic [4*FRAC_KEEP-1:0] frac_bcd;
   logic [3:0]             int_ndig;
   logic                   sign_out;
   logic                   err;
   modport master (
      output start, sign_in, int_dec, frac_dec, ovf_in,
      input  busy, done, int_bcd, frac_bcd, int_ndig, sign_out, err
   );
   modport slave (
      input  start, sign_in, int_dec, frac_dec, ovf_in,
      output busy, done, int_bcd, frac_bcd, int_ndig, sign_out, err
   );
endinterface

// File: rtl/dec2bcd.sv
// dec2bcd: sequential binary-to-packed-BCD converter for the integer and fraction parts of a split float.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dec2bcd_if.slave: start/sign_in/int_dec/frac_dec/ovf_in in;
//        busy/done/int_bcd/frac_bcd/int_ndig/sign_out/err out (held between done pulses)
//   FRAC_KEEP (1..9) leading fraction digits exported, lower digits truncated
module dec2bcd #(parameter int FRAC_KEEP = 9) (
   input  logic     clk,
   input  logic     rst,
   dec2bcd_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
   state_t      state, state_n;
   logic [5:0]  cnt;
   logic [71:0] int_sr, frac_sr;
   logic        sign_r;
   logic [39:0] int_res, frac_res;
   logic        int_ovf, frac_ovf;
   logic [31:0] int_sat;
   logic [35:0] frac_sat;
   logic [3:0]  ndig;

   function automatic logic [39:0] add3(input logic [39:0] b);
      logic [39:0] r;
      for (int i = 0; i < 10; i++)
         r[4*i+:4] = (b[4*i+:4] >= 4'd5) ? b[4*i+:4] + 4'd3 : b[4*i+:4];
      return r;
   endfunction

   // one double-dabble iteration: correct all BCD digits, then shift in the next binary MSB
   function automatic logic [71:0] step(input logic [71:0] sr);
      logic [71:0] t;
      t = {add3(sr[71:32]), sr[31:0]};
      return {t[70:0], 1'b0};
   endfunction

   assign bus.busy = (state != IDLE);

   always_comb begin
      state_n = (state == IDLE)  ? ((bus.start && !bus.ovf_in) ? SHIFT : IDLE) :
                (state == SHIFT) ? ((cnt == 6'd31) ? FIN : SHIFT) : IDLE;
   end

   // after 32 shifts the binary field is fully consumed and the BCD digits sit in the top 40 bits
   always_comb begin
      int_res  = int_sr[71:32];
      frac_res = frac_sr[71:32];
      int_ovf  = |int_res[39:32];
      frac_ovf = |frac_res[39:36];
      int_sat  = int_ovf ? 32'h9999_9999 : int_res[31:0];
      frac_sat = frac_ovf ? 36'h9_9999_9999 : frac_res[35:0];
      ndig     = 4'd1;
      for (int i = 1; i < 8; i++)
         if (int_sat[4*i+:4] != 4'd0) ndig = 4'(i + 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         int_sr       <= '0;
         frac_sr      <= '0;
         sign_r       <= 1'b0;
         bus.done     <= 1'b0;
         bus.int_bcd  <= '0;
         bus.frac_bcd <= '0;
         bus.int_ndig <= '0;
         bus.sign_out <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         state    <= state_n;
         bus.done <= 1'b0;
         if (state == IDLE && bus.start && bus.ovf_in) begin
            bus.int_bcd  <= '0;
            bus.frac_bcd <= '0;
            bus.int_ndig <= 4'd1;
            bus.err      <= 1'b1;
            bus.sign_out <= bus.sign_in;
            bus.done     <= 1'b1;
         end
         if (state == IDLE && bus.start && !bus.ovf_in) begin
            int_sr  <= {40'b0, bus.int_dec};
            frac_sr <= {40'b0, bus.frac_dec};
            sign_r  <= bus.sign_in;
            cnt     <= '0;
         end
         if (state == SHIFT) begin
            int_sr  <= step(int_sr);
            frac_sr <= step(frac_sr);
            cnt     <= cnt + 6'd1;
         end
         if (state == FIN) begin
            bus.int_bcd  <= int_sat;
            bus.frac_bcd <= frac_sat[35 -: 4*FRAC_KEEP];
            bus.int_ndig <= ndig;
            bus.err      <= int_ovf | frac_ovf;
            bus.sign_out <= sign_r;
            bus.done     <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dec2bcd.sv
// tb_dec2bcd: directed-vector bench for dec2bcd at FRAC_KEEP=9 and FRAC_KEEP=4 driven in parallel.
module tb_dec2bcd;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dec2bcd_if #(.FRAC_KEEP(9)) b9();
   dec2bcd_if #(.FRAC_KEEP(4)) b4();
   dec2bcd #(.FRAC_KEEP(9)) dut9 (.clk(clk), .rst(rst), .bus(b9.slave));
   dec2bcd #(.FRAC_KEEP(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

   assign b4.start    = b9.start;
   assign b4.sign_in  = b9.sign_in;
   assign b4.int_dec  = b9.int_dec;
   assign b4.frac_dec = b9.frac_dec;
   assign b4.ovf_in   = b9.ovf_in;

   int   nvec = 0;
   int   nerr = 0;
   int   lat, ndone;
   logic busy_k, busy_any;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // one request; inputs are scrambled right after the sampling edge, optional stray start at edge k+inj
   task automatic run(input logic sg, input logic [31:0] iv, input logic [31:0] fv, input logic ov, input int inj);
      @(negedge clk);
      b9.sign_in  = sg;
      b9.int_dec  = iv;
      b9.frac_dec = fv;
      b9.ovf_in   = ov;
      b9.start    = 1'b1;
      @(posedge clk);
      #1;
      b9.start    = 1'b0;
      b9.sign_in  = ~sg;
      b9.int_dec  = ~iv;
      b9.frac_dec = ~fv;
      b9.ovf_in   = 1'b0;
      busy_k   = b9.busy;
      busy_any = busy_k;
      lat      = -1;
      ndone    = 0;
      if (b9.done) begin
         lat   = 0;
         ndone = 1;
      end
      for (int n = 1; n <= 40; n++) begin
         if (n == inj) begin
            b9.start   = 1'b1;
            b9.int_dec = 32'd7;
         end
         @(posedge clk);
         #1;
         b9.start = 1'b0;
         busy_any |= b9.busy;
         if (b9.done) begin
            ndone++;
            if (lat < 0) lat = n;
         end
      end
   endtask

   task automatic watch_no_done(input string tag);
      ndone = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (b9.done || b9.busy) ndone++;
      end
      check(tag, 64'(ndone), 64'd0);
   endtask

   initial begin
      b9.start    = 1'b0;
      b9.sign_in  = 1'b0;
      b9.int_dec  = '0;
      b9.frac_dec = '0;
      b9.ovf_in   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  64'(b9.busy), 64'd0);
      check("rst_done",  64'(b9.done), 64'd0);
      check("rst_int",   64'(b9.int_bcd), 64'd0);
      check("rst_frac",  64'(b9.frac_bcd), 64'd0);
      check("rst_frac4", 64'(b4.frac_bcd), 64'd0);
      check("rst_ndig",  64'(b9.int_ndig), 64'd0);
      check("rst_sign",  64'(b9.sign_out), 64'd0);
      check("rst_err",   64'(b9.err), 64'd0);
      rst = 1'b0;

      run(1'b0, 32'd12345, 32'd750000000, 1'b0, 0);
      check("t1_lat",   64'(lat), 64'd33);
      check("t1_ndone", 64'(ndone), 64'd1);
      check("t1_busy",  64'(busy_k), 64'd1);
      check("t1_int",   64'(b9.int_bcd), 64'h0001_2345);
      check("t1_frac",  64'(b9.frac_bcd), 64'h7_5000_0000);
      check("t1_frac4", 64'(b4.frac_bcd), 64'h7500);
      check("t1_ndig",  64'(b9.int_ndig), 64'd5);
      check("t1_err",   64'(b9.err), 64'd0);
      check("t1_sign",  64'(b9.sign_out), 64'd0);

      run(1'b0, 32'd0, 32'd1953125, 1'b0, 0);
      check("t2_int",   64'(b9.int_bcd), 64'd0);
      check("t2_ndig",  64'(b9.int_ndig), 64'd1);
      check("t2_frac",  64'(b9.frac_bcd), 64'h0_0195_3125);
      check("t2_frac4", 64'(b4.frac_bcd), 64'h0019);

      run(1'b1, 32'd16777216, 32'd0, 1'b0, 0);
      check("t3_int",   64'(b9.int_bcd), 64'h1677_7216);
      check("t3_ndig",  64'(b9.int_ndig), 64'd8);
      check("t3_sign",  64'(b9.sign_out), 64'd1);
      check("t3_frac4", 64'(b4.frac_bcd), 64'h0000);
      check("t3_err",   64'(b9.err), 64'd0);

      run(1'b0, 32'd100000000, 32'd1000000000, 1'b0, 0);
      check("t4_int",   64'(b9.int_bcd), 64'h9999_9999);
      check("t4_frac",  64'(b9.frac_bcd), 64'h9_9999_9999);
      check("t4_frac4", 64'(b4.frac_bcd), 64'h9999);
      check("t4_ndig",  64'(b9.int_ndig), 64'd8);
      check("t4_err",   64'(b9.err), 64'd1);

      run(1'b1, 32'd555, 32'd123, 1'b1, 0);
      check("ovf_lat",   64'(lat), 64'd0);
      check("ovf_ndone", 64'(ndone), 64'd1);
      check("ovf_busy",  64'(busy_any), 64'd0);
      check("ovf_err",   64'(b9.err), 64'd1);
      check("ovf_int",   64'(b9.int_bcd), 64'd0);
      check("ovf_frac",  64'(b9.frac_bcd), 64'd0);
      check("ovf_ndig",  64'(b9.int_ndig), 64'd1);
      check("ovf_sign",  64'(b9.sign_out), 64'd1);

      run(1'b0, 32'd99999999, 32'd999999999, 1'b0, 0);
      check("t5_lat",  64'(lat), 64'd33);
      check("t5_int",  64'(b9.int_bcd), 64'h9999_9999);
      check("t5_frac", 64'(b9.frac_bcd), 64'h9_9999_9999);
      check("t5_err",  64'(b9.err), 64'd0);
      check("t5_ndig", 64'(b9.int_ndig), 64'd8);

      run(1'b0, 32'd42, 32'd5, 1'b0, 5);
      check("t6_lat",   64'(lat), 64'd33);
      check("t6_ndone", 64'(ndone), 64'd1);
      check("t6_int",   64'(b9.int_bcd), 64'h42);
      check("t6_frac",  64'(b9.frac_bcd), 64'h0_0000_0005);
      check("t6_ndig",  64'(b9.int_ndig), 64'd2);

      @(negedge clk);
      b9.int_dec  = 32'd4321;
      b9.frac_dec = 32'd1;
      b9.start    = 1'b1;
      @(posedge clk);
      #1;
      b9.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 64'(b9.busy), 64'd0);
      check("abort_done", 64'(b9.done), 64'd0);
      check("abort_int",  64'(b9.int_bcd), 64'd0);
      check("abort_frac", 64'(b9.frac_bcd), 64'd0);
      check("abort_ndig", 64'(b9.int_ndig), 64'd0);
      check("abort_err",  64'(b9.err), 64'd0);
      watch_no_done("abort_quiet");

      @(negedge clk);
      b9.int_dec = 32'd77;
      b9.start   = 1'b1;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      b9.start = 1'b0;
      rst      = 1'b0;
      check("rst_start_busy", 64'(b9.busy), 64'd0);
      watch_no_done("rst_start_quiet");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
